// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over a req/ack port and hands them to decode.
// Optional ack watchdog enabled by defining IFU_TIMEOUT_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        J,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [25:0] AddressJ,
   input  logic [15:0] extender,
   output logic        fetch_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] VALID = 2'd2;

   logic [1:0]  state;
   logic [31:0] instReg;
   logic [31:0] nextPc;
   logic [31:0] branchOff;
   logic        timedOut;

   // Request and valid decode straight from state so a reset drops them immediately.
   assign imem_req    = (state == FETCH);
   assign inst_valid  = (state == VALID);
   assign imem_addr   = pc;
   assign pc_plus4    = pc + 32'd4;
   assign instruction = inst_valid ? instReg : NOP_WORD;
   assign branchOff   = {{14{extender[15]}}, extender, 2'b00};

   always_comb begin
      nextPc = pc_plus4;
      if (J)
         nextPc = {pc_plus4[31:28], AddressJ, 2'b00};
      else if (Branch && Zero)
         nextPc = pc_plus4 + branchOff;
   end

`ifdef IFU_TIMEOUT_EN
   logic [7:0] waitCnt;
   logic       errReg;

   assign timedOut  = (state == FETCH) && !imem_ack && (waitCnt == 8'(TIMEOUT - 1));
   assign fetch_err = errReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= 8'd0;
         errReg  <= 1'b0;
      end else begin
         // Held at zero outside FETCH, so each fetch starts counting from zero.
         if (state != FETCH)
            waitCnt <= 8'd0;
         else if (!imem_ack)
            waitCnt <= waitCnt + 8'd1;
         if (timedOut)
            errReg <= 1'b1;
      end
   end
`else
   assign timedOut  = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instReg <= NOP_WORD;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imem_ack) begin
                  instReg <= imem_rdata;
                  state   <= VALID;
               end else if (timedOut) begin
                  instReg <= NOP_WORD;
                  state   <= VALID;
               end
            end
            VALID: begin
               if (inst_ready) begin
                  pc    <= nextPc;
                  state <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
